ram_arbiter: RTL
================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter D_WIDTH, default 8, data width of the shared RAM port.
REQ-002 Parameter A_WIDTH, default 8, address width of the shared RAM port.
REQ-003 clk  input  1  single clock; all logic samples on posedge clk.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 mN_req  input  1  (N=0,1) master N requests one RAM access this cycle.
REQ-006 mN_we  input  1  (N=0,1) 1 = write, 0 = read; qualified by mN_req.
REQ-007 mN_lock  input  1  (N=0,1) master N asks to keep ownership after this access.
REQ-008 mN_addr  input  A_WIDTH  (N=0,1) access address.
REQ-009 mN_wdata  input  D_WIDTH  (N=0,1) write data.
REQ-010 mN_gnt  output  1  (N=0,1) combinational; access accepted this cycle.
REQ-011 mN_rvalid  output  1  (N=0,1) registered; read or write data for master N is on mN_rdata.
REQ-012 mN_rdata  output  D_WIDTH  (N=0,1) RAM output routed to master N; 0 when mN_rvalid=0.
REQ-013 ram_we  output  1  write enable to the RAM port.
REQ-014 ram_addr  output  A_WIDTH  address to the RAM port.
REQ-015 ram_din  output  D_WIDTH  write data to the RAM port.
REQ-016 ram_dout  input  D_WIDTH  RAM registered output; valid one cycle after the access; write returns the written data.

Function
REQ-017 At most one of m0_gnt and m1_gnt SHALL be 1 in any cycle.
REQ-018 A transfer occurs in a cycle when mN_req=1 and mN_gnt=1; ram_we = mN_we, ram_addr = mN_addr, ram_din = mN_wdata of the granted master, in that same cycle.
REQ-019 With no grant, ram_we SHALL be 0; ram_addr and ram_din SHALL be 0.
REQ-020 The FSM SHALL have states IDLE, OWN0, OWN1; reset state IDLE.
REQ-021 IDLE: single requester is granted; both requesting -> grant the master not named by the priority pointer last, i.e. round-robin.
REQ-022 Priority pointer SHALL record the last granted master; reset value = 1, so m0 wins the first conflict.
REQ-023 A transfer with mN_lock=1 SHALL move the FSM to OWNN; a transfer with mN_lock=0 SHALL move it to IDLE.
REQ-024 OWNN: only master N may be granted; the other master's request SHALL be held off (gnt=0) regardless of priority.
REQ-025 OWNN with mN_req=0 SHALL keep the state (ownership persists across idle cycles until an unlocked transfer).
REQ-026 OWNN SHALL be forced to IDLE after 16 consecutive cycles in OWNN if the other master is requesting (starvation bound); that cycle grants the other master as in IDLE.
REQ-027 mN_rvalid SHALL pulse 1 exactly one cycle after each transfer by master N (reads and writes), and no other time.
REQ-028 mN_rdata SHALL equal ram_dout when mN_rvalid=1.
REQ-029 Back-to-back transfers SHALL be supported: a new transfer may be granted every cycle; throughput 1 access per cycle.
REQ-030 A deasserted mN_req while not granted SHALL drop the request without side effects; no request queueing inside the block.

Reset
REQ-031 While reset_n=0 at a clock edge: FSM -> IDLE, pointer -> 1, ownership counter -> 0, m0_rvalid=m1_rvalid=0 on the next cycle.
REQ-032 While reset_n=0: m0_gnt=m1_gnt=0 and ram_we=0 combinationally, so no RAM write occurs during reset.
REQ-033 Reset asserted the cycle after a read transfer SHALL suppress that read's rvalid.
REQ-034 Reset mid-ownership SHALL release the lock; after release the first conflict SHALL go to m0.

Verification
REQ-035 Scenario: after reset, both masters req read addr 0x10/0x20 on the same cycle -> m0_gnt=1, ram_addr=0x10; next cycle m1 granted, ram_addr=0x20; rvalid pulses follow each by one cycle with the RAM contents.
REQ-036 Scenario: m0 writes 0xA5 to 0x05 with lock=1, m1 requests continuously -> m1_gnt=0 while m0 holds the lock; m0 reads 0x05 unlocked -> m0_rdata=0xA5 with m0_rvalid; next cycle m1 granted.
REQ-037 Scenario: m0 locks and idles, m1 requests for 16 cycles -> m1_gnt=1 on the 17th cycle in OWN0; state IDLE afterwards.
REQ-038 Scenario: both request every cycle for 8 cycles, lock=0 -> grants alternate m0,m1,m0,...; 4 rvalid pulses each.
REQ-039 Scenario: reset_n=0 for one cycle, asserted while m1 read in flight and m1 holds the lock -> m1_rvalid stays 0, ram_we=0 during reset, next conflict granted to m0.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-master arbiter for a single-port synchronous RAM: round-robin on conflict,
// lockable ownership with a starvation bound, and per-master read-data return.
module ram_arbiter #(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               m0_req,
    input  logic               m0_we,
    input  logic               m0_lock,
    input  logic [A_WIDTH-1:0] m0_addr,
    input  logic [D_WIDTH-1:0] m0_wdata,
    output logic               m0_gnt,
    output logic               m0_rvalid,
    output logic [D_WIDTH-1:0] m0_rdata,
    input  logic               m1_req,
    input  logic               m1_we,
    input  logic               m1_lock,
    input  logic [A_WIDTH-1:0] m1_addr,
    input  logic [D_WIDTH-1:0] m1_wdata,
    output logic               m1_gnt,
    output logic               m1_rvalid,
    output logic [D_WIDTH-1:0] m1_rdata,
    output logic               ram_we,
    output logic [A_WIDTH-1:0] ram_addr,
    output logic [D_WIDTH-1:0] ram_din,
    input  logic [D_WIDTH-1:0] ram_dout
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t     state, state_next;
    logic       ptr;
    logic [4:0] own_cnt;
    logic       expired;
    logic       arb;
    logic       rv0, rv1;

    assign expired = (own_cnt == 5'd16);

    always_comb begin
        state_next = state;
        arb        = 1'b0;
        m0_gnt     = 1'b0;
        m1_gnt     = 1'b0;
        case (state)
            IDLE: arb = 1'b1;
            OWN0: if (expired && m1_req) arb = 1'b1; else m0_gnt = m0_req;
            OWN1: if (expired && m0_req) arb = 1'b1; else m1_gnt = m1_req;
            default: arb = 1'b1;
        endcase
        // ptr holds the last granted master, so the other one wins a conflict
        if (arb) begin
            if (m0_req && m1_req) begin
                m0_gnt = ptr;
                m1_gnt = !ptr;
            end else begin
                m0_gnt = m0_req;
                m1_gnt = m1_req;
            end
        end
        if (!reset_n) begin
            m0_gnt = 1'b0;
            m1_gnt = 1'b0;
        end
        if (m0_gnt)      state_next = m0_lock ? OWN0 : IDLE;
        else if (m1_gnt) state_next = m1_lock ? OWN1 : IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            ptr     <= 1'b1;
            own_cnt <= 5'd0;
            rv0     <= 1'b0;
            rv1     <= 1'b0;
        end else begin
            state <= state_next;
            if (m0_gnt)      ptr <= 1'b0;
            else if (m1_gnt) ptr <= 1'b1;
            // counts consecutive cycles spent in one ownership state, saturating at 16
            if (state != IDLE && state_next == state)
                own_cnt <= expired ? own_cnt : own_cnt + 5'd1;
            else
                own_cnt <= 5'd0;
            rv0 <= m0_gnt;
            rv1 <= m1_gnt;
        end
    end

    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (m0_gnt) begin
            ram_we   = m0_we;
            ram_addr = m0_addr;
            ram_din  = m0_wdata;
        end else if (m1_gnt) begin
            ram_we   = m1_we;
            ram_addr = m1_addr;
            ram_din  = m1_wdata;
        end
    end

    // Masked by reset so a read in flight when reset arrives never reports data
    assign m0_rvalid = rv0 & reset_n;
    assign m1_rvalid = rv1 & reset_n;
    assign m0_rdata  = m0_rvalid ? ram_dout : '0;
    assign m1_rdata  = m1_rvalid ? ram_dout : '0;

endmodule
